// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the multi-port byte-serial memory controller.
// Holds the FSM state encoding, request size codes and the RAM byte width.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam int RAM_W = 8;

    localparam logic [2:0] SIZE_1 = 3'd1;
    localparam logic [2:0] SIZE_2 = 3'd2;
    localparam logic [2:0] SIZE_4 = 3'd4;

    // Any size code other than 1 or 2 is treated as a full 4-byte transfer.
    function automatic logic [2:0] sizeToBytes(input logic [2:0] size);
        case (size)
            SIZE_1:  return SIZE_1;
            SIZE_2:  return SIZE_2;
            default: return SIZE_4;
        endcase
    endfunction

endpackage

// File: rtl/multi_port_mem_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// wrapping around, as a one-hot vector.
module rr_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int PTR_W     = 1
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [PTR_W-1:0]     i_ptr,
    output logic [NUM_PORTS-1:0] o_grant
);

    // Scan from farthest to nearest offset so the nearest requester wins.
    always_comb begin
        o_grant = '0;
        for (int off = NUM_PORTS - 1; off >= 0; off--) begin
            if (i_req[(int'(i_ptr) + off) % NUM_PORTS]) begin
                o_grant = '0;
                o_grant[(int'(i_ptr) + off) % NUM_PORTS] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_port_mem_ctrl.sv
// Multi-port controller serialising 1/2/4-byte loads and stores onto a
// byte-wide synchronous RAM, with round-robin port selection and read flush.
module multi_port_mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int                   NUM_PORTS  = 2,
    parameter int                   ADDR_W     = 32,
    parameter int                   DATA_W     = 32,
    parameter logic [NUM_PORTS-1:0] FLUSH_MASK = 'b01
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [RAM_W-1:0]              i_ram_din,
    output logic [RAM_W-1:0]              o_ram_dout,
    output logic [ADDR_W-1:0]             o_ram_addr,
    output logic                          o_ram_wr,
    input  logic                          i_flush,
    input  logic [NUM_PORTS-1:0]          i_req_valid,
    output logic [NUM_PORTS-1:0]          o_req_ready,
    input  logic [NUM_PORTS-1:0]          i_req_wr,
    input  logic [NUM_PORTS*ADDR_W-1:0]   i_req_addr,
    input  logic [NUM_PORTS*3-1:0]        i_req_size,
    input  logic [NUM_PORTS*DATA_W-1:0]   i_req_wdata,
    output logic [NUM_PORTS-1:0]          o_resp_valid,
    output logic [NUM_PORTS*DATA_W-1:0]   o_resp_data
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    state_t                r_state;
    logic [PTR_W-1:0]      r_rrPtr;
    logic [PTR_W-1:0]      r_curPort;
    logic [2:0]            r_cnt;
    logic [2:0]            r_size;
    logic [ADDR_W-1:0]     r_ramAddr;
    logic                  r_ramWr;
    logic [RAM_W-1:0]      r_ramDout;
    logic [DATA_W-1:0]     r_wrShift;
    logic [DATA_W-1:0]     r_rdBuf;
    logic [NUM_PORTS-1:0]  r_respValid;
    logic [DATA_W-1:0]     r_respData [NUM_PORTS];

    logic [NUM_PORTS-1:0]  r_slotFull;
    logic [NUM_PORTS-1:0]  r_slotWr;
    logic [ADDR_W-1:0]     r_slotAddr  [NUM_PORTS];
    logic [2:0]            r_slotSize  [NUM_PORTS];
    logic [DATA_W-1:0]     r_slotWdata [NUM_PORTS];

    logic [NUM_PORTS-1:0]  w_flushPorts;
    logic [NUM_PORTS-1:0]  w_flushKill;
    logic [NUM_PORTS-1:0]  w_accept;
    logic [NUM_PORTS-1:0]  w_arbReq;
    logic [NUM_PORTS-1:0]  w_grant;
    logic                  w_grantAny;
    logic [PTR_W-1:0]      w_grantIdx;
    logic [PTR_W-1:0]      w_nextPtr;
    logic [1:0]            w_capIdx;
    logic [DATA_W-1:0]     w_rdMerged;
    logic                  w_abort;

    // Flushable ports neither accept new requests nor keep pending reads while flushing.
    assign w_flushPorts = {NUM_PORTS{i_flush}} & FLUSH_MASK;
    assign w_flushKill  = w_flushPorts & r_slotFull & ~r_slotWr;
    assign o_req_ready  = ~r_slotFull & ~w_flushPorts;
    assign w_accept     = i_req_valid & o_req_ready;
    assign w_arbReq     = (r_state == IDLE) ? (r_slotFull & ~w_flushKill) : '0;
    assign w_grantAny   = |w_grant;
    assign w_nextPtr    = (w_grantIdx == PTR_W'(NUM_PORTS - 1)) ? '0 : w_grantIdx + PTR_W'(1);
    assign w_capIdx     = 2'(r_cnt - 3'd1);
    assign w_abort      = i_flush && FLUSH_MASK[r_curPort];

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PTR_W)
    ) u_arbiter (
        .i_req   (w_arbReq),
        .i_ptr   (r_rrPtr),
        .o_grant (w_grant)
    );

    always_comb begin
        w_grantIdx = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_grant[p]) w_grantIdx = PTR_W'(p);
        end
    end

    // The byte arriving this cycle belongs to the address driven one cycle earlier.
    always_comb begin
        w_rdMerged = r_rdBuf;
        w_rdMerged[{w_capIdx, 3'b000} +: RAM_W] = i_ram_din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slotFull <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_accept[p]) begin
                    r_slotFull[p]  <= 1'b1;
                    r_slotWr[p]    <= i_req_wr[p];
                    r_slotAddr[p]  <= i_req_addr[p*ADDR_W +: ADDR_W];
                    r_slotSize[p]  <= i_req_size[p*3 +: 3];
                    r_slotWdata[p] <= i_req_wdata[p*DATA_W +: DATA_W];
                end else if (w_grant[p] || w_flushKill[p]) begin
                    r_slotFull[p] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rrPtr     <= '0;
            r_curPort   <= '0;
            r_cnt       <= '0;
            r_size      <= '0;
            r_ramAddr   <= '0;
            r_ramWr     <= 1'b0;
            r_ramDout   <= '0;
            r_wrShift   <= '0;
            r_rdBuf     <= '0;
            r_respValid <= '0;
            for (int p = 0; p < NUM_PORTS; p++) r_respData[p] <= '0;
        end else begin
            r_ramWr     <= 1'b0;
            r_respValid <= '0;
            case (r_state)
                IDLE: begin
                    if (w_grantAny) begin
                        r_curPort <= w_grantIdx;
                        r_rrPtr   <= w_nextPtr;
                        r_cnt     <= '0;
                        r_size    <= sizeToBytes(r_slotSize[w_grantIdx]);
                        r_ramAddr <= r_slotAddr[w_grantIdx];
                        if (r_slotWr[w_grantIdx]) begin
                            r_state   <= WRITE;
                            r_ramWr   <= 1'b1;
                            r_ramDout <= r_slotWdata[w_grantIdx][RAM_W-1:0];
                            r_wrShift <= r_slotWdata[w_grantIdx] >> RAM_W;
                        end else begin
                            r_state <= READ;
                            r_rdBuf <= '0;
                        end
                    end
                end
                // Addresses lead captured bytes by one cycle; the extra cycle drains the last byte.
                READ: begin
                    if (w_abort) begin
                        r_state <= IDLE;
                    end else begin
                        if (r_cnt != 3'd0) r_rdBuf <= w_rdMerged;
                        if (r_cnt + 3'd1 < r_size) r_ramAddr <= r_ramAddr + ADDR_W'(1);
                        if (r_cnt == r_size) begin
                            r_respValid[r_curPort] <= 1'b1;
                            r_respData[r_curPort]  <= w_rdMerged;
                            r_state                <= IDLE;
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                        end
                    end
                end
                WRITE: begin
                    if (r_cnt + 3'd1 < r_size) begin
                        r_ramWr   <= 1'b1;
                        r_ramAddr <= r_ramAddr + ADDR_W'(1);
                        r_ramDout <= r_wrShift[RAM_W-1:0];
                        r_wrShift <= r_wrShift >> RAM_W;
                        r_cnt     <= r_cnt + 3'd1;
                    end else begin
                        r_respValid[r_curPort] <= 1'b1;
                        r_state                <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_ram_addr   = r_ramAddr;
    assign o_ram_wr     = r_ramWr;
    assign o_ram_dout   = r_ramDout;
    assign o_resp_valid = r_respValid;

    always_comb begin
        o_resp_data = '0;
        for (int p = 0; p < NUM_PORTS; p++) o_resp_data[p*DATA_W +: DATA_W] = r_respData[p];
    end

endmodule

// File: tb/tb_multi_port_mem_ctrl.sv
// Directed bench for multi_port_mem_ctrl: one task per scenario with
// hand-computed expectations against a byte-wide RAM model.
module tb_multi_port_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ramDin;
    logic [7:0]  ramDout;
    logic [31:0] ramAddr;
    logic        ramWr;
    logic        flush;
    logic [1:0]  reqValid;
    logic [1:0]  reqReady;
    logic [1:0]  reqWr;
    logic [63:0] reqAddr;
    logic [5:0]  reqSize;
    logic [63:0] reqWdata;
    logic [1:0]  respValid;
    logic [63:0] respData;

    logic [7:0]  mem [0:4095];
    int          checks = 0;
    int          passes = 0;

    multi_port_mem_ctrl #(
        .NUM_PORTS  (2),
        .ADDR_W     (32),
        .DATA_W     (32),
        .FLUSH_MASK (2'b01)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_ram_din    (ramDin),
        .o_ram_dout   (ramDout),
        .o_ram_addr   (ramAddr),
        .o_ram_wr     (ramWr),
        .i_flush      (flush),
        .i_req_valid  (reqValid),
        .o_req_ready  (reqReady),
        .i_req_wr     (reqWr),
        .i_req_addr   (reqAddr),
        .i_req_size   (reqSize),
        .i_req_wdata  (reqWdata),
        .o_resp_valid (respValid),
        .o_resp_data  (respData)
    );

    always #5 clk = ~clk;

    // Synchronous read RAM: returns the byte for last cycle's address.
    always @(posedge clk) ramDin <= mem[ramAddr[11:0]];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int p, input logic wr, input logic [31:0] addr,
                                 input logic [2:0] size, input logic [31:0] wdata);
        reqValid[p]          = 1'b1;
        reqWr[p]             = wr;
        reqAddr[p*32 +: 32]  = addr;
        reqSize[p*3 +: 3]    = size;
        reqWdata[p*32 +: 32] = wdata;
    endtask

    task automatic clearStimulus;
        reqValid = '0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        checks++; if (ramWr !== 1'b0) $display("[TB] FAIL reset_ram_wr: got %b want 0", ramWr); else passes++;
        checks++; if (ramAddr !== 32'h0) $display("[TB] FAIL reset_ram_addr: got %h want 0", ramAddr); else passes++;
        checks++; if (ramDout !== 8'h0) $display("[TB] FAIL reset_ram_dout: got %h want 0", ramDout); else passes++;
        checks++; if (respValid !== 2'b00) $display("[TB] FAIL reset_resp_valid: got %b want 00", respValid); else passes++;
        checks++; if (respData !== 64'h0) $display("[TB] FAIL reset_resp_data: got %h want 0", respData); else passes++;
        rst = 1'b0;
        tick;
        checks++; if (reqReady !== 2'b11) $display("[TB] FAIL reset_ready: got %b want 11", reqReady); else passes++;
    endtask

    task automatic test_read4;
        applyStimulus(0, 1'b0, 32'h100, 3'd4, 32'h0);
        tick;
        clearStimulus();
        for (int k = 0; k < 4; k++) begin
            tick;
            checks++; if (ramAddr !== 32'h100 + k) $display("[TB] FAIL read4_addr%0d: got %h want %h", k, ramAddr, 32'h100 + k); else passes++;
            checks++; if (ramWr !== 1'b0) $display("[TB] FAIL read4_wr%0d: got %b want 0", k, ramWr); else passes++;
        end
        tick;
        checks++; if (respValid !== 2'b00) $display("[TB] FAIL read4_early_resp: got %b want 00", respValid); else passes++;
        tick;
        checks++; if (respValid !== 2'b01) $display("[TB] FAIL read4_resp_valid: got %b want 01", respValid); else passes++;
        checks++; if (respData[31:0] !== 32'h44332211) $display("[TB] FAIL read4_resp_data: got %h want 44332211", respData[31:0]); else passes++;
        tick;
        checks++; if (respValid !== 2'b00) $display("[TB] FAIL read4_pulse: got %b want 00", respValid); else passes++;
        checks++; if (respData[31:0] !== 32'h44332211) $display("[TB] FAIL read4_hold: got %h want 44332211", respData[31:0]); else passes++;
    endtask

    task automatic test_write2;
        applyStimulus(1, 1'b1, 32'h200, 3'd2, 32'h0000BEEF);
        tick;
        clearStimulus();
        tick;
        checks++; if (ramWr !== 1'b1) $display("[TB] FAIL write2_wr0: got %b want 1", ramWr); else passes++;
        checks++; if (ramAddr !== 32'h200) $display("[TB] FAIL write2_addr0: got %h want 200", ramAddr); else passes++;
        checks++; if (ramDout !== 8'hEF) $display("[TB] FAIL write2_byte0: got %h want ef", ramDout); else passes++;
        tick;
        checks++; if (ramWr !== 1'b1) $display("[TB] FAIL write2_wr1: got %b want 1", ramWr); else passes++;
        checks++; if (ramAddr !== 32'h201) $display("[TB] FAIL write2_addr1: got %h want 201", ramAddr); else passes++;
        checks++; if (ramDout !== 8'hBE) $display("[TB] FAIL write2_byte1: got %h want be", ramDout); else passes++;
        checks++; if (respValid !== 2'b00) $display("[TB] FAIL write2_early_resp: got %b want 00", respValid); else passes++;
        tick;
        checks++; if (respValid !== 2'b10) $display("[TB] FAIL write2_resp_valid: got %b want 10", respValid); else passes++;
        checks++; if (ramWr !== 1'b0) $display("[TB] FAIL write2_wr_done: got %b want 0", ramWr); else passes++;
    endtask

    task automatic test_back_to_back;
        applyStimulus(0, 1'b0, 32'h100, 3'd1, 32'h0);
        applyStimulus(1, 1'b1, 32'h210, 3'd1, 32'h0000005A);
        tick;
        clearStimulus();
        tick;
        checks++; if (ramAddr !== 32'h100) $display("[TB] FAIL b2b_port0_first: got %h want 100", ramAddr); else passes++;
        checks++; if (ramWr !== 1'b0) $display("[TB] FAIL b2b_port0_read: got %b want 0", ramWr); else passes++;
        tick;
        tick;
        checks++; if (respValid !== 2'b01) $display("[TB] FAIL b2b_resp0: got %b want 01", respValid); else passes++;
        checks++; if (respData[31:0] !== 32'h00000011) $display("[TB] FAIL b2b_data0: got %h want 00000011", respData[31:0]); else passes++;
        tick;
        checks++; if (ramWr !== 1'b1 || ramAddr !== 32'h210 || ramDout !== 8'h5A)
            $display("[TB] FAIL b2b_port1_write: got wr=%b addr=%h dout=%h want wr=1 addr=210 dout=5a", ramWr, ramAddr, ramDout);
        else passes++;
        tick;
        checks++; if (respValid !== 2'b10) $display("[TB] FAIL b2b_resp1: got %b want 10", respValid); else passes++;
    endtask

    task automatic test_flush;
        logic sawResp0;
        logic sawWr;
        sawResp0 = 1'b0;
        sawWr    = 1'b0;
        applyStimulus(0, 1'b0, 32'h100, 3'd4, 32'h0);
        applyStimulus(1, 1'b1, 32'h220, 3'd2, 32'h00001234);
        tick;
        clearStimulus();
        tick;
        checks++; if (ramAddr !== 32'h100) $display("[TB] FAIL flush_read_started: got %h want 100", ramAddr); else passes++;
        tick;
        flush = 1'b1;
        #1;
        checks++; if (reqReady[0] !== 1'b0) $display("[TB] FAIL flush_ready0: got %b want 0", reqReady[0]); else passes++;
        tick;
        flush = 1'b0;
        sawResp0 = sawResp0 | respValid[0];
        sawWr    = sawWr | ramWr;
        tick;
        checks++; if (ramWr !== 1'b1 || ramAddr !== 32'h220 || ramDout !== 8'h34)
            $display("[TB] FAIL flush_write_byte0: got wr=%b addr=%h dout=%h want wr=1 addr=220 dout=34", ramWr, ramAddr, ramDout);
        else passes++;
        sawResp0 = sawResp0 | respValid[0];
        tick;
        checks++; if (ramWr !== 1'b1 || ramAddr !== 32'h221 || ramDout !== 8'h12)
            $display("[TB] FAIL flush_write_byte1: got wr=%b addr=%h dout=%h want wr=1 addr=221 dout=12", ramWr, ramAddr, ramDout);
        else passes++;
        sawResp0 = sawResp0 | respValid[0];
        tick;
        checks++; if (respValid !== 2'b10) $display("[TB] FAIL flush_write_resp: got %b want 10", respValid); else passes++;
        for (int i = 0; i < 4; i++) begin
            tick;
            sawResp0 = sawResp0 | respValid[0];
        end
        checks++; if (sawWr !== 1'b0) $display("[TB] FAIL flush_no_wr_after_abort: got %b want 0", sawWr); else passes++;
        checks++; if (sawResp0 !== 1'b0) $display("[TB] FAIL flush_no_resp0: got %b want 0", sawResp0); else passes++;
        checks++; if (respData[31:0] !== 32'h00000011) $display("[TB] FAIL flush_data0_kept: got %h want 00000011", respData[31:0]); else passes++;
    endtask

    task automatic test_reset_mid_write;
        logic sawActivity;
        sawActivity = 1'b0;
        applyStimulus(1, 1'b1, 32'h230, 3'd4, 32'hCAFEF00D);
        tick;
        clearStimulus();
        tick;
        checks++; if (ramWr !== 1'b1 || ramDout !== 8'h0D) $display("[TB] FAIL rstmid_write_started: got wr=%b dout=%h want wr=1 dout=0d", ramWr, ramDout); else passes++;
        rst = 1'b1;
        tick;
        checks++; if (ramWr !== 1'b0 || ramAddr !== 32'h0 || ramDout !== 8'h0)
            $display("[TB] FAIL rstmid_ram_outputs: got wr=%b addr=%h dout=%h want all 0", ramWr, ramAddr, ramDout);
        else passes++;
        checks++; if (respValid !== 2'b00 || respData !== 64'h0) $display("[TB] FAIL rstmid_resp: got valid=%b data=%h want 0", respValid, respData); else passes++;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            sawActivity = sawActivity | ramWr | (|respValid);
        end
        checks++; if (sawActivity !== 1'b0) $display("[TB] FAIL rstmid_no_response: got %b want 0", sawActivity); else passes++;
        checks++; if (reqReady !== 2'b11) $display("[TB] FAIL rstmid_ready: got %b want 11", reqReady); else passes++;
    endtask

    task automatic test_read1;
        applyStimulus(0, 1'b0, 32'h300, 3'd1, 32'h0);
        tick;
        clearStimulus();
        tick;
        checks++; if (ramAddr !== 32'h300) $display("[TB] FAIL read1_addr: got %h want 300", ramAddr); else passes++;
        tick;
        checks++; if (respValid !== 2'b00) $display("[TB] FAIL read1_early_resp: got %b want 00", respValid); else passes++;
        tick;
        checks++; if (respValid !== 2'b01) $display("[TB] FAIL read1_resp_valid: got %b want 01", respValid); else passes++;
        checks++; if (respData[31:0] !== 32'h00000080) $display("[TB] FAIL read1_zero_ext: got %h want 00000080", respData[31:0]); else passes++;
    endtask

    task automatic test_size_default;
        applyStimulus(1, 1'b0, 32'h100, 3'd0, 32'h0);
        tick;
        clearStimulus();
        for (int k = 0; k < 4; k++) tick;
        checks++; if (ramAddr !== 32'h103) $display("[TB] FAIL size0_last_addr: got %h want 103", ramAddr); else passes++;
        tick;
        checks++; if (respValid !== 2'b00) $display("[TB] FAIL size0_early_resp: got %b want 00", respValid); else passes++;
        tick;
        checks++; if (respValid !== 2'b10) $display("[TB] FAIL size0_resp_valid: got %b want 10", respValid); else passes++;
        checks++; if (respData[63:32] !== 32'h44332211) $display("[TB] FAIL size0_resp_data: got %h want 44332211", respData[63:32]); else passes++;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h100] = 8'h11;
        mem[12'h101] = 8'h22;
        mem[12'h102] = 8'h33;
        mem[12'h103] = 8'h44;
        mem[12'h300] = 8'h80;
        rst      = 1'b1;
        flush    = 1'b0;
        reqValid = '0;
        reqWr    = '0;
        reqAddr  = '0;
        reqSize  = '0;
        reqWdata = '0;

        test_reset();
        test_read4();
        test_write2();
        test_back_to_back();
        test_flush();
        test_reset_mid_write();
        test_read1();
        test_size_default();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/multi_port_mem_ctrl.md
MULTI_PORT_MEM_CTRL -- requirements
Module: multi_port_mem_ctrl

Interface
REQ-001 Parameter NUM_PORTS, default 2: number of requester ports.
REQ-002 Parameter ADDR_W, default 32: address width.
REQ-003 Parameter DATA_W, default 32: request data width; a multiple of 8.
REQ-004 Parameter FLUSH_MASK, default 'b01: bit p set means port p reads are cancellable by flush.
REQ-005 clk  in  1  clock.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 ram_din  in  8  byte returned by RAM for the address driven in the previous cycle.
REQ-008 ram_dout  out  8  write byte.
REQ-009 ram_addr  out  ADDR_W  RAM byte address.
REQ-010 ram_wr  out  1  1 = write, 0 = read.
REQ-011 flush_in  in  1  pipeline rollback.
REQ-012 req_valid / req_ready  in / out  NUM_PORTS  per-port request handshake.
REQ-013 req_wr  in  NUM_PORTS  1 = store, 0 = load.
REQ-014 req_addr  in  NUM_PORTS*ADDR_W  byte address.
REQ-015 req_size  in  NUM_PORTS*3  byte count; 1, 2 or 4.
REQ-016 req_wdata  in  NUM_PORTS*DATA_W  store data.
REQ-017 resp_valid  out  NUM_PORTS  one-cycle completion pulse.
REQ-018 resp_data  out  NUM_PORTS*DATA_W  load data.

Function
REQ-019 Each port SHALL have one pending slot; req_ready[p] = slot empty; a request is accepted when req_valid[p] && req_ready[p].
REQ-020 The FSM SHALL have states IDLE, READ and WRITE.
REQ-021 Grant: in IDLE, the first pending port at or after rr_ptr (wrapping) is granted; its slot is cleared; rr_ptr = granted+1 mod NUM_PORTS.
REQ-022 Transfers SHALL be little-endian: byte k at addr+k uses data bits [8k+:8].
REQ-023 req_size values other than 1 or 2 SHALL be treated as 4.
REQ-024 Read of S bytes granted in cycle G: ram_addr = addr+k in cycle G+1+k (pipelined, one address per cycle).
REQ-025 Read data: byte k is captured from ram_din in cycle G+2+k.
REQ-026 Read response: resp_valid[p] is high in cycle G+S+2; resp_data holds the bytes, zero-extended.
REQ-027 Write of S bytes: ram_wr = 1 with ram_addr = addr+k and ram_dout = byte k in cycle G+1+k.
REQ-028 Write response: resp_valid[p] is high in cycle G+S+1.
REQ-029 ram_wr SHALL be 0 in every cycle without a write byte.
REQ-030 The response cycle SHALL be an IDLE cycle eligible for a new grant, giving back-to-back operations.
REQ-031 resp_data[p] SHALL hold its value until that port's next response.
REQ-032 Flush: clears the pending reads of ports with FLUSH_MASK set.
REQ-033 Flush: an in-flight read of a flushable port is aborted (state to IDLE, no resp_valid).
REQ-034 Flush: requests from flushable ports are not accepted in the flush cycle.
REQ-035 Flush SHALL never drop writes or non-flushable reads.
REQ-036 A request accepted in the same cycle its port's response fires is legal.

Reset
REQ-037 On rst: state IDLE, all slots empty, rr_ptr 0, ram_wr 0, ram_addr 0, ram_dout 0, resp_valid 0, resp_data 0; req_ready all 1 from the next cycle.
REQ-038 rst mid-operation SHALL abort the operation with no response.
REQ-039 rst SHALL take priority over flush_in.

Structure
REQ-040 Package mem_ctrl_pkg SHALL hold the FSM state enum, size encodings and the RAM byte width constant.
REQ-041 Round-robin selection SHALL be a sub-module rr_arbiter (request vector plus pointer in, one-hot grant out).

Verification
REQ-042 Port0 read addr 0x100 size 4, RAM bytes 11 22 33 44: ram_addr 0x100..0x103 on consecutive cycles; resp_data[0] = 0x44332211 at G+6.
REQ-043 Port1 write addr 0x200 size 2 data 0xBEEF: ram_wr for 2 cycles, bytes EF then BE; resp_valid[1] at G+3.
REQ-044 Both ports pending from IDLE with rr_ptr 0: port0 served, then port1; port1 granted in port0's response cycle.
REQ-045 Flush during port0 read, with FLUSH_MASK 'b01: read aborted, no resp_valid[0], ram_wr stays 0; port1 write pending in parallel completes.
REQ-046 rst asserted mid-write: all outputs 0 next cycle; no response; req_ready all 1 afterwards.
REQ-047 Port0 read addr 0x300 size 1, RAM byte 0x80: resp_data[0] = 0x00000080.
